poca_response_serializer: RTL and testbench
===========================================

# poca_response_serializer

Downstream stage of the POCA primitive top: captures the wide authentication response (chip public key concatenated with its hash) when the primitive asserts `response_ready`, and streams it to the HSM/tester link as fixed-width words over a valid/ready handshake. It decouples the 539-bit parallel result from the narrow external bus and reports completion and overrun status.

## Interface
- `MULT_SIZE`, default 283: public-key width.
- `HASH_SIZE`, default 256: hash width.
- `WORD_SIZE`, default 32: output word width.
- `clk  input  1`: single clock, rising edge.
- `rst  input  1`: reset, asynchronous and active-high.
- `response  input  MULT_SIZE+HASH_SIZE`: response from the POCA primitive; sampled only at capture.
- `response_ready  input  1`: level from the primitive; a 0→1 transition requests a capture.
- `tx_data  output  WORD_SIZE`: current output word.
- `tx_valid  output  1`: `tx_data` is valid.
- `tx_ready  input  1`: sink accepts the word; a transfer occurs on a clock edge with `tx_valid && tx_ready`.
- `tx_last  output  1`: marks the final word of a frame.
- `busy  output  1`: high in any state other than IDLE.
- `done  output  1`: one-cycle pulse after the last word has transferred.
- `overrun  output  1`: sticky; set when a capture request arrives while the block is busy.

## Operation
- Padded width: `P = NUM_WORDS*WORD_SIZE`, where `NUM_WORDS = ceil((MULT_SIZE+HASH_SIZE)/WORD_SIZE)`. With the defaults, NUM_WORDS = 17 and P = 544.
- Padded frame: `{zero pad, response}`. Word 0 is the most-significant `WORD_SIZE` slice, bits P-1 to P-WORD_SIZE. Words go out MSB-first. For the defaults, word 0 carries 5 zero bits followed by the top 27 response bits.
- Edge detect: `rq` is a registered copy of `response_ready`. A capture request is `response_ready && !rq`.
- FSM states are IDLE, SEND, CSUM, DONE.
  - IDLE: on a request, load the padded frame into a shift register, clear the word counter, go to SEND.
  - SEND: drive `tx_valid`=1 with `tx_data` equal to the shift-register top word. On each transfer, shift left by `WORD_SIZE` and increment the counter. On the transfer of word NUM_WORDS-1, go to CSUM if the checksum is enabled, otherwise go to DONE.
  - CSUM: drive the checksum word with `tx_valid`=1. On transfer, go to DONE.
  - DONE: `done`=1 for exactly one cycle, then return to IDLE.
- `tx_last`=1 only while the final word of the frame is presented: the checksum word if the checksum is enabled, otherwise word NUM_WORDS-1.
- A capture request in any state other than IDLE is ignored (no reload) and sets `overrun`. `overrun` clears only on reset.
- A request in the DONE cycle counts as overrun.
- `response_ready` held high does not retrigger a capture.
- Reset mid-frame aborts the frame immediately; no partial `tx_last` or `done` is emitted.

## Timing
- Reset values: all outputs are 0, `rq`=0, state is IDLE.
- The request is sampled at clock edge k. `tx_valid` and word 0 are visible after edge k.
- With `tx_ready` tied high, one word transfers per cycle:
  - Checksum disabled: `done` is high in the cycle after the 17th transfer.
  - Checksum enabled: `done` is high in the cycle after the 18th transfer.
- Backpressure: while `tx_valid && !tx_ready`, `tx_data`, `tx_valid` and `tx_last` must hold stable.
- `busy` rises after edge k and falls after the DONE cycle.
- The earliest next capture is from the IDLE cycle, which requires `response_ready` to go low and high again.

## Configuration
- `POCA_SER_CHECKSUM_EN` defined:
  - A checksum word is appended after the data words.
  - The checksum is the bitwise XOR of all NUM_WORDS padded data words, accumulated as each word transfers.
  - The frame is NUM_WORDS+1 words long.
- `POCA_SER_CHECKSUM_EN` undefined:
  - No CSUM state and no accumulator logic.
  - The frame is NUM_WORDS words long.

## Structure
- Shared package `poca_pkg`:
  - Holds the default size constants (283/256/32).
  - Holds the NUM_WORDS ceiling-division function.
  - Holds the FSM state typedef (IDLE, SEND, CSUM, DONE).
- Sub-module `poca_xor_accum` (a clearable, enabled XOR accumulator) is instantiated only under `POCA_SER_CHECKSUM_EN`. The shift register, counter and edge detect stay in the top module.

## Test plan
- `response` = 539'h1 with `tx_ready` high → words 0–15 are 0x00000000 and word 16 is 0x00000001. The checksum is 0x00000001 with `tx_last` on it. `done` pulses once.
- `response` = all ones → word 0 is 0x07FFFFFF and words 1–16 are 0xFFFFFFFF. The checksum is 0x07FFFFFF.
- Random backpressure (`tx_ready` low 50% of cycles) with `response` = {283'h503213f7…, 256-bit hash} → the word stream is identical to the no-stall run, and data stays stable during stalls.
- Pulse `response_ready` again during word 5 → the stream is unchanged, `overrun`=1 and stays set. After the frame, a fresh 0→1 edge captures normally.
- Assert `rst` during word 8 → all outputs are 0 at once. A subsequent request restarts the frame from word 0.
- Hold `response_ready` high for 100 cycles → exactly one frame and one `done` pulse.

Source files
------------

// File: rtl/poca_pkg.sv
// Shared definitions for the POCA response path: default sizes, the
// word-count helper and the serializer FSM state type.
// Optional build macro: POCA_SER_CHECKSUM_EN (adds a trailing XOR checksum word).
package poca_pkg;

    localparam int unsigned DEF_MULT_SIZE = 283;
    localparam int unsigned DEF_HASH_SIZE = 256;
    localparam int unsigned DEF_WORD_SIZE = 32;

    // Number of WORD_SIZE words needed to carry `total` bits (ceiling division).
    function automatic int unsigned num_words(input int unsigned total, input int unsigned word);
        return (total + word - 1) / word;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2,
        DONE = 2'd3
    } ser_state_t;

endpackage

// File: rtl/poca_response_serializer_if.sv
// Word-stream link from the response serializer to the HSM/tester.
// The master drives data/valid/last, and the slave returns ready.
interface poca_response_serializer_if
    import poca_pkg::*;
#(
    parameter int unsigned WORD_SIZE = DEF_WORD_SIZE
);
    logic [WORD_SIZE-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_last;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/poca_xor_accum.sv
// Clearable, enabled XOR accumulator used to build the frame checksum.
module poca_xor_accum #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear has priority so a new frame always starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q ^ d;
        end
    end

endmodule

// File: rtl/poca_response_serializer.sv
// Captures the wide POCA response on a rising edge of response_ready and
// streams it MSB-first as WORD_SIZE words over a valid/ready link.
// Optional build macro: POCA_SER_CHECKSUM_EN (appends the XOR of all data words).
module poca_response_serializer
    import poca_pkg::*;
#(
    parameter int unsigned MULT_SIZE = DEF_MULT_SIZE,
    parameter int unsigned HASH_SIZE = DEF_HASH_SIZE,
    parameter int unsigned WORD_SIZE = DEF_WORD_SIZE
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [MULT_SIZE+HASH_SIZE-1:0] response,
    input  logic                           response_ready,
    poca_response_serializer_if.master     tx,
    output logic                           busy,
    output logic                           done,
    output logic                           overrun
);

    localparam int unsigned RESP_W    = MULT_SIZE + HASH_SIZE;
    localparam int unsigned NUM_WORDS = num_words(RESP_W, WORD_SIZE);
    localparam int unsigned PAD_W     = NUM_WORDS * WORD_SIZE;
    localparam int unsigned CNT_W     = $clog2(NUM_WORDS + 1);
`ifdef POCA_SER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    ser_state_t           state;
    logic [PAD_W-1:0]     shreg;
    logic [PAD_W-1:0]     shreg_next;
    logic [PAD_W-1:0]     frame;
    logic [CNT_W-1:0]     cnt;
    logic                 rq;
    logic                 req;
    logic                 xfer;
    logic                 last_data;
    logic [WORD_SIZE-1:0] word_q;
    logic                 valid_q;
    logic                 last_q;

    assign frame      = PAD_W'(response);
    assign shreg_next = shreg << WORD_SIZE;
    assign req        = response_ready && !rq;
    assign xfer       = valid_q && tx.tx_ready;
    assign last_data  = (cnt == CNT_W'(NUM_WORDS - 1));

    assign tx.tx_data  = word_q;
    assign tx.tx_valid = valid_q;
    assign tx.tx_last  = last_q;

`ifdef POCA_SER_CHECKSUM_EN
    logic [WORD_SIZE-1:0] acc_q;
    logic                 acc_clr;
    logic                 acc_en;

    assign acc_clr = (state == IDLE) && req;
    assign acc_en  = (state == SEND) && xfer;

    poca_xor_accum #(
        .WIDTH(WORD_SIZE)
    ) u_accum (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .en  (acc_en),
        .d   (word_q),
        .q   (acc_q)
    );
`endif

    // Registered copy of response_ready for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rq <= 1'b0;
        end else begin
            rq <= response_ready;
        end
    end

    // Sticky overrun: any capture request outside IDLE, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (req && (state != IDLE)) begin
            overrun <= 1'b1;
        end
    end

    // Frame FSM; word_q always holds the word currently presented on the link,
    // so data/valid/last stay frozen while the sink stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (req) begin
                        shreg   <= frame;
                        word_q  <= frame[PAD_W-1 -: WORD_SIZE];
                        cnt     <= '0;
                        valid_q <= 1'b1;
                        last_q  <= !CSUM_EN && (NUM_WORDS == 1);
                        busy    <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        shreg <= shreg_next;
                        cnt   <= cnt + 1'b1;
                        if (last_data) begin
`ifdef POCA_SER_CHECKSUM_EN
                            // Accumulator has not yet absorbed this word, so fold it in here.
                            word_q <= acc_q ^ word_q;
                            last_q <= 1'b1;
                            state  <= CSUM;
`else
                            word_q  <= '0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
`endif
                        end else begin
                            word_q <= shreg_next[PAD_W-1 -: WORD_SIZE];
                            last_q <= !CSUM_EN && (cnt == CNT_W'(NUM_WORDS - 2));
                        end
                    end
                end
`ifdef POCA_SER_CHECKSUM_EN
                CSUM: begin
                    if (xfer) begin
                        word_q  <= '0;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
`endif
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    word_q  <= '0;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poca_response_serializer.sv
// Scoreboard bench for poca_response_serializer: expected words are queued at
// stimulus time and a negedge monitor pops and compares on each transfer.
// Build with POCA_SER_CHECKSUM_EN defined to cover the checksum variant.
module tb_poca_response_serializer;

    localparam int RW = 539;
    localparam int NW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] response;
    logic          response_ready;
    logic          busy, done, overrun;
    bit            stall_en = 1'b0;

    poca_response_serializer_if #(.WORD_SIZE(32)) tx_if ();

    poca_response_serializer #(
        .MULT_SIZE(283),
        .HASH_SIZE(256),
        .WORD_SIZE(32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .response       (response),
        .response_ready (response_ready),
        .tx             (tx_if.master),
        .busy           (busy),
        .done           (done),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_passed = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;

    logic [31:0] exp_data_q[$];
    bit          exp_last_q[$];

    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    bit          exp_done_next = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic logic [31:0] word_of(input logic [RW-1:0] r, input int i);
        logic [NW*32-1:0] p;
        p = {5'b0, r};
        return p[NW*32-1-32*i -: 32];
    endfunction

    function automatic void push_word(input logic [31:0] w, input bit last);
        exp_data_q.push_back(w);
        exp_last_q.push_back(last);
    endfunction

    function automatic void push_model(input logic [RW-1:0] r);
        logic [31:0] cs;
        cs = '0;
        for (int i = 0; i < NW; i++) begin
`ifdef POCA_SER_CHECKSUM_EN
            push_word(word_of(r, i), 1'b0);
`else
            push_word(word_of(r, i), i == NW - 1);
`endif
            cs = cs ^ word_of(r, i);
        end
`ifdef POCA_SER_CHECKSUM_EN
        push_word(cs, 1'b1);
`endif
    endfunction

    // Sink ready: tied high, or random 50% backpressure.
    always @(posedge clk) begin
        #1;
        tx_if.tx_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops the scoreboard on each transfer, checks stall stability and done timing.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall    = 1'b0;
            exp_done_next = 1'b0;
        end else begin
            if (exp_done_next) begin
                check("done_after_last", done, 1);
                exp_done_next = 1'b0;
            end
            if (done) done_cnt++;
            if (prev_stall) begin
                check("stall_valid", tx_if.tx_valid, 1);
                check("stall_data", tx_if.tx_data, prev_data);
                check("stall_last", tx_if.tx_last, prev_last);
            end
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                if (exp_data_q.size() == 0) begin
                    check("unexpected_word", tx_if.tx_data, 32'hxxxxxxxx);
                end else begin
                    logic [31:0] ed;
                    bit          el;
                    ed = exp_data_q.pop_front();
                    el = exp_last_q.pop_front();
                    check($sformatf("word%0d_data", xfer_cnt), tx_if.tx_data, ed);
                    check($sformatf("word%0d_last", xfer_cnt), tx_if.tx_last, el);
                    if (el) exp_done_next = 1'b1;
                end
                xfer_cnt++;
            end
            prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
            prev_data  = tx_if.tx_data;
            prev_last  = tx_if.tx_last;
        end
    end

    task automatic run_frame(input logic [RW-1:0] r, input bit stall, input int pulse_at);
        int base, d0;
        bit got, pulsed;
        stall_en = stall;
        @(posedge clk); #2;
        response = r;
        response_ready = 1'b1;
        base = xfer_cnt;
        d0 = done_cnt;
        @(posedge clk); #2;
        check("valid_after_req", tx_if.tx_valid, 1);
        check("busy_after_req", busy, 1);
        response_ready = 1'b0;
        got = 1'b0;
        pulsed = 1'b0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk); #1;
            if (pulse_at >= 0 && !pulsed && (xfer_cnt - base) >= pulse_at) begin
                response_ready = 1'b1;
                pulsed = 1'b1;
            end else begin
                response_ready = 1'b0;
            end
            if (done) got = 1'b1;
        end
        response_ready = 1'b0;
        check("done_seen", got, 1);
        @(negedge clk); #1;
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("queue_drained", exp_data_q.size(), 0);
        check("done_pulses", done_cnt - d0, 1);
        stall_en = 1'b0;
    endtask

    logic [RW-1:0] r3;
    logic [RW-1:0] ones;
    int            d0;

    initial begin
        rst = 1'b1;
        response = '0;
        response_ready = 1'b0;
        r3 = {283'h503213f7_0badf00d_13572468_a5a5c3c3_deadbeef_01234567_89abcdef_fedcba98_7,
              256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19};
        ones = '1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid", tx_if.tx_valid, 0);
        check("rst_data", tx_if.tx_data, 0);
        check("rst_last", tx_if.tx_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;

        // response = 1: sixteen zero words then 1; checksum 1.
        for (int i = 0; i < 16; i++) push_word(32'h0, 1'b0);
`ifdef POCA_SER_CHECKSUM_EN
        push_word(32'h1, 1'b0);
        push_word(32'h1, 1'b1);
`else
        push_word(32'h1, 1'b1);
`endif
        run_frame(539'h1, 1'b0, -1);

        // All ones: top word has 5 pad zeros; even count of FFFFFFFF cancels in checksum.
        push_word(32'h07FFFFFF, 1'b0);
        for (int i = 1; i < 16; i++) push_word(32'hFFFFFFFF, 1'b0);
`ifdef POCA_SER_CHECKSUM_EN
        push_word(32'hFFFFFFFF, 1'b0);
        push_word(32'h07FFFFFF, 1'b1);
`else
        push_word(32'hFFFFFFFF, 1'b1);
`endif
        run_frame(ones, 1'b0, -1);

        // Key+hash vector without and with random backpressure.
        push_model(r3);
        run_frame(r3, 1'b0, -1);
        push_model(r3);
        run_frame(r3, 1'b1, -1);

        // Second request mid-frame is ignored and flagged.
        check("overrun_before", overrun, 0);
        push_model(r3);
        run_frame(r3, 1'b0, 5);
        check("overrun_set", overrun, 1);
        push_model(ones);
        run_frame(ones, 1'b0, -1);
        check("overrun_sticky", overrun, 1);

        // Reset during word 8 aborts immediately.
        push_model(r3);
        @(posedge clk); #2;
        response = r3;
        response_ready = 1'b1;
        d0 = xfer_cnt;
        @(posedge clk); #2;
        response_ready = 1'b0;
        for (int c = 0; c < 200 && (xfer_cnt - d0) < 8; c++) @(negedge clk);
        check("reached_word8", xfer_cnt - d0, 8);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", tx_if.tx_valid, 0);
        check("arst_data", tx_if.tx_data, 0);
        check("arst_last", tx_if.tx_last, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_overrun", overrun, 0);
        exp_data_q.delete();
        exp_last_q.delete();
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        push_model(r3);
        run_frame(r3, 1'b0, -1);

        // Level held high for 100 cycles yields exactly one frame.
        push_model(ones);
        @(posedge clk); #2;
        response = ones;
        response_ready = 1'b1;
        d0 = done_cnt;
        repeat (100) @(posedge clk);
        #2;
        response_ready = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("hold_one_done", done_cnt - d0, 1);
        check("hold_queue_drained", exp_data_q.size(), 0);
        check("hold_idle", busy, 0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
